// File: rtl/fact_cu.sv
// Control unit for the iterative factorial datapath (CNT, MUL, REG, CMP).
// Moore FSM with a debug state output.
//
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous reset, active-high
//   GO     : start request, level (sampled in IDLE/DONE/ERROR only)
//   GT     : count > 1 from the comparator
//   IN_ERR : N out of range (N > 12)
//   LD_CNT : load CNT with N
//   EN_CNT : decrement CNT
//   SEL    : REG mux select (0 = constant 1, 1 = product)
//   LD_REG : load REG
//   OE     : product output enable
//   DONE   : computation complete
//   ERR    : range error
//   CS     : current state code
module fact_cu (
  input  logic       clk,
  input  logic       rst,
  input  logic       GO,
  input  logic       GT,
  input  logic       IN_ERR,
  output logic       LD_CNT,
  output logic       EN_CNT,
  output logic       SEL,
  output logic       LD_REG,
  output logic       OE,
  output logic       DONE,
  output logic       ERR,
  output logic [2:0] CS
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_MULT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0] state;
  logic [2:0] nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Codes 6 and 7 fall through to the default and recover to IDLE.
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:  nxt = GO ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = IN_ERR ? S_ERROR : S_CHECK;
      S_CHECK: nxt = GT ? S_MULT : S_DONE;
      S_MULT:  nxt = S_CHECK;
      S_DONE:  nxt = GO ? S_DONE : S_IDLE;
      S_ERROR: nxt = GO ? S_ERROR : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    LD_CNT = 1'b0;
    EN_CNT = 1'b0;
    SEL    = 1'b0;
    LD_REG = 1'b0;
    OE     = 1'b0;
    DONE   = 1'b0;
    ERR    = 1'b0;
    case (state)
      S_LOAD: begin
        LD_CNT = 1'b1;
        LD_REG = 1'b1;
      end
      S_MULT: begin
        SEL    = 1'b1;
        LD_REG = 1'b1;
        EN_CNT = 1'b1;
      end
      S_DONE: begin
        DONE = 1'b1;
        OE   = 1'b1;
      end
      S_ERROR: ERR = 1'b1;
      default: ;
    endcase
  end

  assign CS = state;

endmodule

// File: tb/tb_fact_cu.sv
// Scoreboard bench for fact_cu with a behavioural CNT/REG datapath.
// Expected states are queued by the stimulus and checked by a monitor.
module tb_fact_cu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       GO = 1'b1;
  logic       GT;
  logic       IN_ERR;
  logic       LD_CNT, EN_CNT, SEL, LD_REG, OE, DONE, ERR;
  logic [2:0] CS;

  fact_cu dut (
    .clk(clk), .rst(rst), .GO(GO), .GT(GT), .IN_ERR(IN_ERR),
    .LD_CNT(LD_CNT), .EN_CNT(EN_CNT), .SEL(SEL), .LD_REG(LD_REG),
    .OE(OE), .DONE(DONE), .ERR(ERR), .CS(CS)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] MULT  = 3'd3;
  localparam logic [2:0] DN    = 3'd4;
  localparam logic [2:0] ERRS  = 3'd5;

  // Datapath model driven by the DUT control word.
  logic [3:0]  nv = 4'd0;
  logic [3:0]  cnt = 4'd0;
  logic [31:0] mreg = 32'd0;

  assign GT     = (cnt > 4'd1);
  assign IN_ERR = (nv > 4'd12);

  always @(posedge clk) begin
    if (LD_CNT)      cnt <= nv;
    else if (EN_CNT) cnt <= cnt - 4'd1;
    if (LD_REG)      mreg <= SEL ? mreg * {28'd0, cnt} : 32'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [2:0]  cs;
    logic [6:0]  o;
    bit          chk;
    logic [31:0] r;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nbad = 0;

  // Required output word {LD_CNT,EN_CNT,SEL,LD_REG,OE,DONE,ERR}.
  function automatic logic [6:0] outs_of(input logic [2:0] s);
    case (s)
      LOAD:    return 7'b1001000;
      MULT:    return 7'b0111000;
      DN:      return 7'b0000110;
      ERRS:    return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic push(input int k, input logic [2:0] s,
                      input bit chk, input logic [31:0] r);
    exp_t e;
    e.due = cyc + k;
    e.cs  = s;
    e.o   = outs_of(s);
    e.chk = chk;
    e.r   = r;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [6:0] got;
    exp_t e;
    got = {LD_CNT, EN_CNT, SEL, LD_REG, OE, DONE, ERR};
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      nvec++;
      if (e.due != cyc || CS !== e.cs || got !== e.o) begin
        nbad++;
        $display("FAIL state@%0d: got cs=%0d outs=%b, want cs=%0d outs=%b (due %0d)",
                 cyc, CS, got, e.cs, e.o, e.due);
      end
      if (e.chk) begin
        nvec++;
        if (mreg !== e.r) begin
          nbad++;
          $display("FAIL reg@%0d: got %0d, want %0d", cyc, mreg, e.r);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One run from IDLE with GO rising; 'hold' extra cycles in the final state.
  // GO is dropped before edge drop_at and raised again two edges later.
  task automatic run(input int n, input logic [31:0] f,
                     input int hold, input int drop_at);
    int k;
    logic [2:0] fin;
    nv  = n[3:0];
    GO  = 1'b1;
    rst = 1'b0;
    k = 1;
    push(k, LOAD, 1'b0, 32'd0);
    if (n > 12) begin
      fin = ERRS;
      k++;
      push(k, ERRS, 1'b0, 32'd0);
    end else begin
      fin = DN;
      k++;
      push(k, CHECK, 1'b0, 32'd0);
      for (int i = 2; i <= n; i++) begin
        k++;
        push(k, MULT, 1'b0, 32'd0);
        k++;
        push(k, CHECK, 1'b0, 32'd0);
      end
      k++;
      push(k, DN, 1'b1, f);
    end
    for (int h = 0; h < hold; h++) begin
      k++;
      push(k, fin, 1'b0, 32'd0);
    end
    for (int e = 1; e <= k; e++) begin
      if (e == drop_at)     GO = 1'b0;
      if (e == drop_at + 2) GO = 1'b1;
      step();
    end
    GO = 1'b0;
    push(1, IDLE, 1'b0, 32'd0);
    step();
    push(1, IDLE, 1'b0, 32'd0);
    step();
  endtask

  initial begin
    // Reset held with GO high.
    step();
    step();
    push(0, IDLE, 1'b0, 32'd0);
    // Release into N=5 with GO still high.
    run(5, 32'd120, 2, -1);
    run(1, 32'd1, 0, -1);
    run(0, 32'd1, 0, -1);
    run(13, 32'd0, 3, -1);
    // Reset during the second MULT of N=6.
    nv = 4'd6;
    GO = 1'b1;
    push(1, LOAD, 1'b0, 32'd0);
    push(2, CHECK, 1'b0, 32'd0);
    push(3, MULT, 1'b0, 32'd0);
    push(4, CHECK, 1'b0, 32'd0);
    push(5, MULT, 1'b0, 32'd0);
    for (int e = 0; e < 5; e++) step();
    rst = 1'b1;
    push(1, IDLE, 1'b0, 32'd0);
    step();
    rst = 1'b0;
    GO  = 1'b0;
    for (int e = 0; e < 4; e++) begin
      push(1, IDLE, 1'b0, 32'd0);
      step();
    end
    // Long DONE hold, then GO glitch during MULT of N=4.
    run(3, 32'd6, 10, -1);
    run(4, 32'd24, 3, 4);
    run(12, 32'd479001600, 1, -1);
    step();
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
